freq_div_monitor: RTL
=====================

# freq_div_monitor

- Measures the divided clock produced by the team's odd-ratio frequency divider.
- Samples the divided clock as a data signal in the fast clock domain and measures period and high time in fast-clock cycles.
- Presents each completed measurement on a valid/ready interface and flags stuck, overrun and (optionally) out-of-tolerance conditions.
- Sits directly downstream of the divider; used for self-test and ratio checking.

## Interface
- CNT_W, 16 — width of counters and results.
- SYNC_STAGES, 2 — synchronizer depth on `div_in` (≥2).
- EXP_PERIOD, 3 — expected period in `clk` cycles (used only with FDM_CHECK_EN).
- TOL, 0 — allowed ±deviation from EXP_PERIOD (used only with FDM_CHECK_EN).

- clk  input  1  fast reference clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- div_in  input  1  divided clock under test, treated as asynchronous data.
- meas_en  input  1  measurement enable; level-sensitive.
- period  output  CNT_W  last measured period (rise to rise) in `clk` cycles.
- high_time  output  CNT_W  last measured high time (rise to fall) in `clk` cycles.
- meas_valid  output  1  result valid; held until accepted.
- meas_ready  input  1  consumer accepts result when `meas_valid & meas_ready`.
- overrun  output  1  sticky: a completed measurement was dropped.
- stuck  output  1  one-cycle pulse: no edge within 2^CNT_W−1 cycles.
- period_err  output  1  registered with result: period outside EXP_PERIOD±TOL.

## Operation
- **Synchronizer:** `div_in` passes through SYNC_STAGES flops, then a one-flop edge detector.
  - `rise_p` = synced & !prev.
  - `fall_p` = !synced & prev.
- **FSM states:** IDLE, ARM, HIGH, LOW.
  - IDLE: counter held at 0. Goes to ARM when `meas_en`=1.
  - ARM: waits for `rise_p`, then goes to HIGH. The first partial period is never reported.
  - HIGH: on `fall_p`, capture `high_time` ← cnt and go to LOW.
  - LOW: on `rise_p`, capture `period` ← cnt, complete the measurement and go to HIGH. Measurements run back-to-back.
  - Any state: `meas_en`=0 → IDLE on the next cycle.
- **Counter:**
  - Set to 1 on each `rise_p`; otherwise increments by 1 every cycle in ARM, HIGH and LOW.
  - On reaching all-ones: saturate, pulse `stuck`, go to ARM, reset the counter to 0. No result is produced.
- **Result handshake:**
  - On completion with `meas_valid`=0, or with `meas_valid & meas_ready` in the same cycle: load `period`/`high_time`; `meas_valid`=1.
  - On completion while `meas_valid & !meas_ready`: the held result is kept unchanged, the new result is discarded, and `overrun` is set.
  - `meas_valid` clears on a cycle with `meas_ready`=1 and no new completion.
  - `meas_en` falling does not clear a pending valid result.
- `overrun` is cleared only by `rst` or by `meas_en`=0.
- A glitch-free input is assumed at the synchronizer output. A fall seen in LOW or ARM, or a rise seen in IDLE, is ignored.

## Timing
- Every output is 0 after reset, and every synchronizer/edge flop is 0.
- Reset takes effect on the next `clk` edge, including mid-measurement. The FSM returns to IDLE and any pending result is lost.
- Input-to-edge latency: a `div_in` change produces `rise_p`/`fall_p` SYNC_STAGES+1 cycles later.
- Latency is constant, so measured widths equal the input widths exactly in `clk` cycles.
- `meas_valid` rises 1 cycle after the completing `rise_p`. `period`/`high_time` update in that same cycle.
- `stuck` asserts 1 cycle after the counter reaches all-ones.
- Minimum measurable period is 2; minimum high time is 1.

## Configuration
- Macro: `FDM_CHECK_EN`.
- Defined: `period_err` is registered with each loaded result and is 1 iff |period − EXP_PERIOD| > TOL. It is held with the result.
- Not defined: `period_err` is tied to 0 and no comparator is built. EXP_PERIOD and TOL are unused.

## Test plan
1. Reset, then `meas_en`=1 with `div_in` pattern high 2 / low 3 repeating and `meas_ready`=1.
   - Required: first `meas_valid` after the second synced rise, with `period`=5 and `high_time`=2.
   - Required: `meas_valid` stays 1 on back-to-back results; `overrun`=0.
2. Same pattern with `meas_ready`=0 for 3 periods.
   - Required: first result held unchanged and `overrun`=1.
   - Required: asserting `meas_ready` for one cycle clears `meas_valid` until the next completion.
3. CNT_W=4 with `div_in` held at 0.
   - Required: `stuck` pulses every 16 cycles; `meas_valid` is never asserted.
4. With FDM_CHECK_EN, EXP_PERIOD=3, TOL=0, drive periods 3 then 4.
   - Required: `period_err`=0 then 1. Without the macro: always 0.
5. Assert `rst` mid-HIGH.
   - Required: all outputs 0 the next cycle.
   - Required: the first result after release follows a fresh ARM, so the partial period is not reported.
6. Drop `meas_en` mid-LOW with a valid result pending.
   - Required: FSM goes to IDLE, `overrun` clears, and the pending result is still accepted by a later `meas_ready`.

Source files
------------

// File: rtl/freq_div_monitor_if.sv
// Result channel of freq_div_monitor: measured period/high time with valid/ready handshake.
interface freq_div_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             meas_ready;
  logic             period_err;

  modport master (
    output period, high_time, meas_valid, period_err,
    input  meas_ready
  );

  modport slave (
    input  period, high_time, meas_valid, period_err,
    output meas_ready
  );
endinterface

// File: rtl/freq_div_monitor.sv
// Measures period and high time of a divided clock sampled in the fast clock domain.
// Optional FDM_CHECK_EN builds the period tolerance comparator behind period_err.
module freq_div_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EXP_PERIOD  = 3,
  parameter int unsigned TOL         = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_in,
  input  logic                meas_en,
  freq_div_monitor_if.master  res,
  output logic                overrun,
  output logic                stuck
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reject configurations the synchronizer or result width cannot support.
  if (SYNC_STAGES < 2 || ((64'(EXP_PERIOD) + 64'(TOL)) >> CNT_W) != 64'd0) begin : g_bad_cfg
    $error("freq_div_monitor: unsupported parameter set");
  end

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hcap_q, hcap_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   ovr_q, ovr_d;
  logic                   stuck_q, stuck_d;

  logic synced_c, rise_c, fall_c, done_c, err_c;

  assign synced_c = sync_q[SYNC_STAGES-1];
  assign rise_c   = synced_c & ~prev_q;
  assign fall_c   = ~synced_c & prev_q;

`ifdef FDM_CHECK_EN
  // Period under measurement lies outside EXP_PERIOD +/- TOL.
  assign err_c = (32'(cnt_q) > EXP_PERIOD + TOL) || (32'(cnt_q) + TOL < EXP_PERIOD);
`else
  assign err_c = 1'b0;
`endif

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], div_in};
    prev_d   = synced_c;
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcap_d   = hcap_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = valid_q;
    err_d    = err_q;
    ovr_d    = ovr_q;
    stuck_d  = 1'b0;
    done_c   = 1'b0;

    if (!meas_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          state_d = S_ARM;
        end
        default: begin
          if (rise_c) begin
            cnt_d = CNT_W'(1);
            if (state_q == S_ARM) begin
              state_d = S_HIGH;
            end else if (state_q == S_LOW) begin
              state_d = S_HIGH;
              done_c  = 1'b1;
            end
          end else if (cnt_q == CNT_MAX) begin
            // No edge for a full counter range: restart from a fresh arm.
            cnt_d   = '0;
            stuck_d = 1'b1;
            state_d = S_ARM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == S_HIGH && fall_c) begin
              hcap_d  = cnt_q;
              state_d = S_LOW;
            end
          end
        end
      endcase
    end

    // A held, unaccepted result wins over a new one; the new one is dropped.
    if (done_c) begin
      if (!valid_q || res.meas_ready) begin
        period_d = cnt_q;
        high_d   = hcap_q;
        err_d    = err_c;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (res.meas_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      hcap_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      hcap_q   <= hcap_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      stuck_q  <= stuck_d;
    end
  end

  assign res.period     = period_q;
  assign res.high_time  = high_q;
  assign res.meas_valid = valid_q;
  assign res.period_err = err_q;
  assign overrun        = ovr_q;
  assign stuck          = stuck_q;

endmodule
